// File: rtl/vec_chunk_feeder.sv
// Source side of the chunked vector stream: reads first/second-row words, zero-pads the tail chunk
// and offers each chunk pair on a valid/ready handshake, pulsing done after the last acceptance.
module vec_chunk_feeder #(
  parameter int NUM_EQ   = 19,
  parameter int ELEM_W   = 64,
  parameter int NO_UNITS = 8,
  parameter int ADDR_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_a,
  input  logic [ADDR_W-1:0]            base_b,
  output logic                         mem_re,
  output logic [ADDR_W-1:0]            mem_addr_a,
  output logic [ADDR_W-1:0]            mem_addr_b,
  input  logic [NO_UNITS*ELEM_W-1:0]   mem_rdata_a,
  input  logic [NO_UNITS*ELEM_W-1:0]   mem_rdata_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NO_UNITS*ELEM_W-1:0]   out_first,
  output logic [NO_UNITS*ELEM_W-1:0]   out_second,
  output logic [ADDR_W-1:0]            out_idx,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);

  localparam int WORD_W = NO_UNITS * ELEM_W;
  localparam int NCHUNK = (NUM_EQ + NO_UNITS - 1) / NO_UNITS;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NCHUNK - 1);

  // state | meaning
  // IDLE  | waiting for start      REQ  | read issued for chunk idx
  // WAIT  | read data returning    HOLD | chunk offered until accepted
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DONE} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   base_a_q, base_b_q, idx_q, idx_d;
  logic                mem_re_q, valid_q, last_q, busy_q, done_q;
  logic [ADDR_W-1:0]   addr_a_q, addr_b_q, out_idx_q;
  logic [WORD_W-1:0]   first_q, second_q, first_d, second_d;

  assign idx_d = idx_q + 1'b1;

  // Elements whose global index lands past NUM_EQ are forced to zero.
  always_comb begin
    first_d  = mem_rdata_a;
    second_d = mem_rdata_b;
    for (int j = 0; j < NO_UNITS; j++) begin
      if (int'(idx_q) * NO_UNITS + j >= NUM_EQ) begin
        first_d[j*ELEM_W +: ELEM_W]  = '0;
        second_d[j*ELEM_W +: ELEM_W] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_a_q  <= '0;
      base_b_q  <= '0;
      idx_q     <= '0;
      mem_re_q  <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      valid_q   <= 1'b0;
      first_q   <= '0;
      second_q  <= '0;
      out_idx_q <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_a_q <= base_a;
            base_b_q <= base_b;
            idx_q    <= '0;
            mem_re_q <= 1'b1;
            addr_a_q <= base_a;
            addr_b_q <= base_b;
            busy_q   <= 1'b1;
            state_q  <= S_REQ;
          end
        end
        S_REQ: begin
          mem_re_q <= 1'b0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          first_q   <= first_d;
          second_q  <= second_d;
          out_idx_q <= idx_q;
          last_q    <= (idx_q == LAST_IDX);
          valid_q   <= 1'b1;
          state_q   <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q    <= idx_d;
              mem_re_q <= 1'b1;
              addr_a_q <= base_a_q + idx_d;
              addr_b_q <= base_b_q + idx_d;
              state_q  <= S_REQ;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_re     = mem_re_q;
  assign mem_addr_a = addr_a_q;
  assign mem_addr_b = addr_b_q;
  assign out_valid  = valid_q;
  assign out_first  = first_q;
  assign out_second = second_q;
  assign out_idx    = out_idx_q;
  assign out_last   = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
